dpram_nw_clr: RTL
=================

// Module: dpram_nw_clr
// PURPOSE
//  Single-clock, parametrised-width true dual-port RAM; generalises the 64-bit composed DPRAM.
//  Adds write-first same-address collision resolution, selectable read latency (1 or 2),
//  per-port read-valid flags and a hardware clear sequencer that zero-fills the array.
//  Used as instruction/data memory for cores whose XLEN or bus width differs from 64.
// PARAMETERS
//  DataWidth    64           word width in bits; multiple of 32 (fatal otherwise)
//  Depth        1280         number of words; >= 2
//  AddrWidth    $clog2(Depth) address width
//  ReadLatency  1            cycles from rden_i to dout_o/valid_o; 1 or 2 (fatal otherwise)
//  ClearOnReset 0            1: zero-fill sequence runs automatically after reset release
// PORTS
//  clk_i      in   1            single clock, all logic on rising edge
//  rstn_i     in   1            asynchronous active-low reset
//  clear_i    in   1            start zero-fill (sampled in IDLE only)
//  busy_o     out  1            1 while the clear sequence owns the array
//  a_addr_i   in   AddrWidth    port A word address
//  a_din_i    in   DataWidth    port A write data
//  a_be_i     in   DataWidth/8  port A byte enables
//  a_wren_i   in   1            port A write request
//  a_rden_i   in   1            port A read request
//  a_dout_o   out  DataWidth    port A read data
//  a_valid_o  out  1            port A read data valid (1-cycle pulse per read)
//  b_*        --   --           port B: identical set (b_addr_i..b_valid_o)
// BEHAVIOUR
//  Reset: all dout_o = 0, valid_o = 0, pipeline regs cleared; FSM -> CLEAR if ClearOnReset
//   else IDLE; clear counter = 0; busy_o = 1 in CLEAR from reset, else 0. Array not reset.
//  FSM IDLE: ports active. clear_i=1 -> CLEAR next cycle, counter=0, busy_o=1.
//  FSM CLEAR: writes 0 to word[counter] each cycle, counter++; after word Depth-1 written
//   -> IDLE; busy_o falls the cycle after last write (busy for exactly Depth cycles).
//   Port requests ignored while busy_o=1: no writes, no valid_o; clear_i ignored.
//  Write: wren_i=1 updates bytes where be_i=1 at the edge; be_i=0 -> no change.
//  Read: rden_i=1 at cycle N -> dout_o/valid_o at N+ReadLatency; valid_o=0 otherwise;
//   dout_o holds last read value when no read completes. Latency-2 stage is a pure
//   pipeline register; back-to-back reads every cycle fully supported.
//  Write-first: read of address X in the same cycle as any write to X (either port)
//   returns the post-write word (per-byte merge of new and old data).
//  Dual write same address: per byte, A wins where a_be_i=1; B bytes apply elsewhere.
//  Out of range (addr >= Depth): write dropped; read returns 0 with valid_o=1.
//  Reset asserted mid-clear: sequence aborts, counter=0, FSM per reset rule; in-flight
//   reads discarded (valid_o=0).
//  Ports independent otherwise; no back-pressure, no ready signal.
// TESTING
//  1 A write addr 5 din 0x1122334455667788 be 0xFF, next cycle A read 5, RL=1
//    -> a_dout_o=0x1122334455667788, a_valid_o=1 one cycle after read.
//  2 A write addr 7 be 0x0F din 0xAAAAAAAA_BBBBBBBB over old 0x0 while B reads addr 7 same
//    cycle -> b_dout_o=0x00000000_BBBBBBBB (write-first merge).
//  3 A and B write addr 3 same cycle, a_be 0xF0 din all 0x11, b_be 0xFF din all 0x22
//    -> read 3 = 0x11111111_22222222.
//  4 Fill array with 0xFF.., pulse clear_i -> busy_o=1 exactly Depth cycles, port writes
//    during busy dropped, every word then reads 0.
//  5 RL=2, reads every cycle addr 0..9 -> data at N+2, valid_o high 10 consecutive cycles.
//  6 Assert rstn_i=0 at clear counter 100, release -> busy_o=0 (ClearOnReset=0), no valid_o
//    from reads issued before reset; read of addr Depth -> 0, valid_o=1.

Source files
------------

// File: rtl/dpram_nw_clr.sv
// Purpose: true dual-port RAM with byte enables, write-first reads and a zero-fill clear sequencer.
// Latency: read data/valid ReadLatency (1 or 2) cycles after rden; writes land on the clock edge.
// Backpressure: none; port requests are dropped while busy_o is high.
module dpram_nw_clr #(
    parameter int DataWidth    = 64,
    parameter int Depth        = 1280,
    parameter int AddrWidth    = $clog2(Depth),
    parameter int ReadLatency  = 1,
    parameter bit ClearOnReset = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic [AddrWidth-1:0]     a_addr_i,
    input  logic [DataWidth-1:0]     a_din_i,
    input  logic [DataWidth/8-1:0]   a_be_i,
    input  logic                     a_wren_i,
    input  logic                     a_rden_i,
    output logic [DataWidth-1:0]     a_dout_o,
    output logic                     a_valid_o,
    input  logic [AddrWidth-1:0]     b_addr_i,
    input  logic [DataWidth-1:0]     b_din_i,
    input  logic [DataWidth/8-1:0]   b_be_i,
    input  logic                     b_wren_i,
    input  logic                     b_rden_i,
    output logic [DataWidth-1:0]     b_dout_o,
    output logic                     b_valid_o
);

    localparam int NumBytes = DataWidth / 8;
    localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    if (DataWidth % 32 != 0) begin : g_bad_width
        $fatal(1, "dpram_nw_clr: DataWidth must be a multiple of 32");
    end
    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "dpram_nw_clr: Depth must be at least 2");
    end
    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $fatal(1, "dpram_nw_clr: ReadLatency must be 1 or 2");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] clr_cnt;

    logic [DataWidth-1:0] mem [Depth];

    // Index 0 is port A, index 1 is port B.
    logic [1:0][AddrWidth-1:0] addr;
    logic [1:0][DataWidth-1:0] din;
    logic [1:0][NumBytes-1:0]  be;
    logic [1:0]                wr_req;
    logic [1:0]                rd_req;
    logic [1:0]                in_rng;
    logic [1:0]                we;
    logic [1:0]                re;
    logic [1:0][DataWidth-1:0] rd_word;

    assign addr   = {b_addr_i, a_addr_i};
    assign din    = {b_din_i, a_din_i};
    assign be     = {b_be_i, a_be_i};
    assign wr_req = {b_wren_i, a_wren_i};
    assign rd_req = {b_rden_i, a_rden_i};
    assign busy_o = (state == ST_CLEAR);

    always_comb begin
        in_rng = '0;
        we     = '0;
        re     = '0;
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = ({1'b0, addr[p]} < DepthExt);
            we[p]     = wr_req[p] && in_rng[p] && (state == ST_IDLE);
            re[p]     = rd_req[p] && (state == ST_IDLE);
        end
    end

    // Write-first: overlay this cycle's writes onto the stored word, B first so A wins per byte.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < 2; p++) begin
            if (in_rng[p]) begin
                rd_word[p] = mem[addr[p]];
                for (int q = 1; q >= 0; q--) begin
                    for (int i = 0; i < NumBytes; i++) begin
                        if (we[q] && be[q][i] && (addr[q] == addr[p])) begin
                            rd_word[p][8*i +: 8] = din[q][8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NumBytes; i++) begin
                if (we[0] && be[0][i]) begin
                    mem[addr[0]][8*i +: 8] <= din[0][8*i +: 8];
                end
                if (we[1] && be[1][i] && !(we[0] && be[0][i] && (addr[0] == addr[1]))) begin
                    mem[addr[1]][8*i +: 8] <= din[1][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ClearOnReset ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LastAddr) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DataWidth-1:0] dout_q;
        logic                 vld_q;

        if (ReadLatency == 2) begin : g_rl2
            logic                 s1_vld;
            logic [DataWidth-1:0] s1_dat;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                    vld_q  <= 1'b0;
                    dout_q <= '0;
                end else begin
                    s1_vld <= re[p];
                    if (re[p]) begin
                        s1_dat <= rd_word[p];
                    end
                    vld_q <= s1_vld;
                    if (s1_vld) begin
                        dout_q <= s1_dat;
                    end
                end
            end
        end else begin : g_rl1
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    vld_q  <= 1'b0;
                    dout_q <= '0;
                end else begin
                    vld_q <= re[p];
                    if (re[p]) begin
                        dout_q <= rd_word[p];
                    end
                end
            end
        end
    end

    assign a_dout_o  = g_port[0].dout_q;
    assign a_valid_o = g_port[0].vld_q;
    assign b_dout_o  = g_port[1].dout_q;
    assign b_valid_o = g_port[1].vld_q;

endmodule
